shift_univ: RTL



---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_frame_cnt.sv | 48 ++++
 rtl/shift_univ.sv | 70 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// a classifier for the ops that advance the frame counter.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'b100;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b110;

  function automatic logic is_shift_op(input logic [MODE_W-1:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame counter: counts shift-class ops modulo WIDTH and pulses frame_done
// for one cycle on the wrap from WIDTH-1 back to 0.
module shift_frame_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     frame_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/shift_univ.sv
// Parametrised universal shift register with serial I/O at both ends,
// parallel load/clear, and a per-WIDTH-shifts frame pulse.
module shift_univ
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [MODE_W-1:0]        mode,
  input  logic                     sin_l,
  input  logic                     sin_r,
  input  logic [WIDTH-1:0]         pdata,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_msb,
  output logic                     sout_lsb,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     frame_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             adv, clr;

  // Reserved encoding 111 falls through to default and behaves as HOLD.
  always_comb begin
    q_d = q_q;
    adv = 1'b0;
    clr = 1'b0;
    if (en) begin
      adv = is_shift_op(mode);
      case (mode)
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
        MODE_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_LOAD: begin
          q_d = pdata;
          clr = 1'b1;
        end
        MODE_CLEAR: begin
          q_d = '0;
          clr = 1'b1;
        end
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q        = q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];

  shift_frame_cnt #(
    .WIDTH(WIDTH)
  ) u_frame_cnt (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .clr       (clr),
    .cnt       (cnt),
    .frame_done(frame_done)
  );

endmodule
